// File: rtl/rename_regfile_v2_if.sv
// Bundle of the dispatch, operand-read, commit, CDB and redirect signals
// that connect rename_regfile_v2 to dispatch and the ROB.
// master: the dispatch/ROB side. slave: the register file.
interface rename_regfile_v2_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREG      = 32,
  parameter int unsigned ROB_DEPTH = 16
);
  localparam int unsigned RW   = $clog2(NREG);
  localparam int unsigned TAGW = $clog2(ROB_DEPTH);

  // dispatch / rename
  logic            dispatch_valid;
  logic            dispatch_ready;
  logic [RW-1:0]   dispatch_rd;
  logic [TAGW-1:0] dispatch_tag;

  // operand reads
  logic [RW-1:0]   rs1_idx;
  logic [RW-1:0]   rs2_idx;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            rs1_valid;
  logic            rs2_valid;
  logic [TAGW-1:0] rs1_tag;
  logic [TAGW-1:0] rs2_tag;

  // in-order commit from the ROB head
  logic            commit_valid;
  logic [RW-1:0]   commit_rd;
  logic [TAGW-1:0] commit_tag;
  logic [XLEN-1:0] commit_val;
  logic            commit_mispredict;
  logic [XLEN-1:0] commit_br_target;

  // common data bus
  logic            cdb_valid;
  logic [TAGW-1:0] cdb_tag;
  logic [XLEN-1:0] cdb_val;

  // redirect
  logic            mem_flush;
  logic            flush;
  logic [XLEN-1:0] br_addr;

  modport master (
    output dispatch_valid, dispatch_rd, dispatch_tag,
    output rs1_idx, rs2_idx,
    output commit_valid, commit_rd, commit_tag, commit_val,
    output commit_mispredict, commit_br_target,
    output cdb_valid, cdb_tag, cdb_val,
    input  dispatch_ready,
    input  rs1_val, rs2_val, rs1_valid, rs2_valid, rs1_tag, rs2_tag,
    input  mem_flush, flush, br_addr
  );

  modport slave (
    input  dispatch_valid, dispatch_rd, dispatch_tag,
    input  rs1_idx, rs2_idx,
    input  commit_valid, commit_rd, commit_tag, commit_val,
    input  commit_mispredict, commit_br_target,
    input  cdb_valid, cdb_tag, cdb_val,
    output dispatch_ready,
    output rs1_val, rs2_val, rs1_valid, rs2_valid, rs1_tag, rs2_tag,
    output mem_flush, flush, br_addr
  );
endinterface

// File: rtl/rename_regfile_v2.sv
// Architectural register file with rename status (value/busy/tag per
// register), commit-to-read bypass and a one-cycle flush FSM on branch
// mispredict. x0 is hardwired to zero and never renamed.
// Optional macro RENAME_RF_CDB_BYPASS_EN forwards CDB broadcasts to busy
// operands with a matching tag; without it the cdb_* signals are ignored.
module rename_regfile_v2 #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREG      = 32,
  parameter int unsigned ROB_DEPTH = 16
) (
  input logic            clk,
  input logic            rst,
  rename_regfile_v2_if.slave bus
);
  localparam int unsigned RW   = $clog2(NREG);
  localparam int unsigned TAGW = $clog2(ROB_DEPTH);

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  state_t          state;
  state_t          state_nx;

  logic [XLEN-1:0] value [NREG];
  logic [TAGW-1:0] tag   [NREG];
  logic [NREG-1:0] busy;
  logic [XLEN-1:0] br_addr_q;

  logic            ready_c;
  logic            flush_c;
  logic            mp_take;
  logic            rename_fire;
  logic            commit_wr;
  logic            same_rd;
  logic            commit_clear;

  logic [RW-1:0]   ridx  [2];
  logic            rvalid[2];
  logic [XLEN-1:0] rval  [2];
  logic [TAGW-1:0] rtag  [2];

  // A mispredict seen during FLUSH is ignored: the ROB is already empty.
  assign mp_take     = bus.commit_valid & bus.commit_mispredict & (state == RUN);
  // Wrong-path dispatch in the mispredict cycle is discarded.
  assign rename_fire = bus.dispatch_valid & ready_c & (bus.dispatch_rd != '0) & ~mp_take;
  assign commit_wr   = bus.commit_valid & (bus.commit_rd != '0);
  assign same_rd     = rename_fire & (bus.dispatch_rd == bus.commit_rd);
  assign commit_clear = commit_wr & busy[bus.commit_rd]
                      & (tag[bus.commit_rd] == bus.commit_tag) & ~same_rd;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nx;
  end

  // FSM next state and handshake/flush outputs
  always_comb begin
    state_nx = state;
    ready_c  = 1'b0;
    flush_c  = 1'b0;
    case (state)
      RUN: begin
        ready_c = 1'b1;
        if (mp_take) state_nx = FLUSH;
      end
      FLUSH: begin
        flush_c  = 1'b1;
        state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  // Redirect target latched on the mispredict edge, held afterwards
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         br_addr_q <= '0;
    else if (mp_take) br_addr_q <= bus.commit_br_target;
  end

  // Register values: every commit to a non-zero rd writes its result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) value[i] <= '0;
    end else if (commit_wr) begin
      value[bus.commit_rd] <= bus.commit_val;
    end
  end

  // Rename status: rename sets busy/tag, matching commit clears busy,
  // a mispredict wipes all mappings
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
      for (int unsigned i = 0; i < NREG; i++) tag[i] <= '0;
    end else if (mp_take) begin
      busy <= '0;
      for (int unsigned i = 0; i < NREG; i++) tag[i] <= '0;
    end else begin
      // Rename is applied after the clear so a same-cycle younger
      // mapping of the same rd always survives.
      if (commit_clear) busy[bus.commit_rd] <= 1'b0;
      if (rename_fire) begin
        busy[bus.dispatch_rd] <= 1'b1;
        tag[bus.dispatch_rd]  <= bus.dispatch_tag;
      end
    end
  end

  assign ridx[0] = bus.rs1_idx;
  assign ridx[1] = bus.rs2_idx;

  // Operand read with x0, committed value, commit bypass and CDB bypass
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      rvalid[p] = 1'b0;
      rval[p]   = '0;
      rtag[p]   = '0;
      if (ridx[p] == '0) begin
        rvalid[p] = 1'b1;
      end else if (!busy[ridx[p]]) begin
        rvalid[p] = 1'b1;
        rval[p]   = value[ridx[p]];
      end else if (bus.commit_valid && (bus.commit_tag == tag[ridx[p]])) begin
        rvalid[p] = 1'b1;
        rval[p]   = bus.commit_val;
      end
`ifdef RENAME_RF_CDB_BYPASS_EN
      else if (bus.cdb_valid && (bus.cdb_tag == tag[ridx[p]])) begin
        rvalid[p] = 1'b1;
        rval[p]   = bus.cdb_val;
      end
`endif
      else begin
        rtag[p] = tag[ridx[p]];
      end
    end
  end

`ifndef RENAME_RF_CDB_BYPASS_EN
  logic cdb_unused;
  assign cdb_unused = ^{bus.cdb_valid, bus.cdb_tag, bus.cdb_val};
`endif

  assign bus.rs1_valid      = rvalid[0];
  assign bus.rs1_val        = rval[0];
  assign bus.rs1_tag        = rtag[0];
  assign bus.rs2_valid      = rvalid[1];
  assign bus.rs2_val        = rval[1];
  assign bus.rs2_tag        = rtag[1];
  assign bus.dispatch_ready = ready_c;
  assign bus.flush          = flush_c;
  assign bus.br_addr        = br_addr_q;
  assign bus.mem_flush      = bus.commit_valid & bus.commit_mispredict;
endmodule

// File: tb/tb_rename_regfile_v2.sv
// Scoreboard bench for rename_regfile_v2: the stimulus process drives one
// vector per cycle and queues the expected outputs tagged with the cycle
// number; the monitor samples on the falling edge and compares.
module tb_rename_regfile_v2;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned ROBD = 16;

  logic clk;
  logic rst;
  int   cyc;
  int   tests;
  int   fails;
  bit   stim_done;

  rename_regfile_v2_if #(.XLEN(XLEN), .NREG(NREG), .ROB_DEPTH(ROBD)) bus ();

  rename_regfile_v2 #(.XLEN(XLEN), .NREG(NREG), .ROB_DEPTH(ROBD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          cyc;
    string       name;
    int          kind;   // 0 rs1, 1 rs2, 2 control
    logic        v;
    logic [31:0] val;
    logic [3:0]  tg;
    logic        rdy;
    logic        fl;
    logic        mf;
    logic [31:0] ba;
  } exp_t;

  exp_t q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
    bus.dispatch_valid    = 1'b0;
    bus.commit_valid      = 1'b0;
    bus.commit_mispredict = 1'b0;
    bus.cdb_valid         = 1'b0;
  endtask

  task automatic chk_rd(input int port, input string nm, input logic v,
                        input logic [31:0] val, input logic [3:0] tg);
    exp_t e;
    e.cyc = cyc; e.name = nm; e.kind = port;
    e.v = v; e.val = val; e.tg = tg;
    e.rdy = 1'b0; e.fl = 1'b0; e.mf = 1'b0; e.ba = '0;
    q.push_back(e);
  endtask

  task automatic chk_ctl(input string nm, input logic rdy, input logic fl,
                         input logic mf, input logic [31:0] ba);
    exp_t e;
    e.cyc = cyc; e.name = nm; e.kind = 2;
    e.v = 1'b0; e.val = '0; e.tg = '0;
    e.rdy = rdy; e.fl = fl; e.mf = mf; e.ba = ba;
    q.push_back(e);
  endtask

  task automatic dispatch(input logic [4:0] rd, input logic [3:0] tg);
    bus.dispatch_valid = 1'b1;
    bus.dispatch_rd    = rd;
    bus.dispatch_tag   = tg;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [3:0] tg, input logic [31:0] val);
    bus.commit_valid = 1'b1;
    bus.commit_rd    = rd;
    bus.commit_tag   = tg;
    bus.commit_val   = val;
  endtask

  // Monitor: compare every expectation scheduled for the current cycle
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        exp_t e;
        e = q.pop_front();
        tests++;
        if (e.cyc < cyc) begin
          fails++;
          $display("FAIL %s: stale expectation from cycle %0d seen at %0d", e.name, e.cyc, cyc);
        end else if (e.kind == 0) begin
          if (bus.rs1_valid !== e.v || bus.rs1_val !== e.val || bus.rs1_tag !== e.tg) begin
            fails++;
            $display("FAIL %s: rs1 got valid=%b val=%h tag=%0d, want valid=%b val=%h tag=%0d",
                     e.name, bus.rs1_valid, bus.rs1_val, bus.rs1_tag, e.v, e.val, e.tg);
          end
        end else if (e.kind == 1) begin
          if (bus.rs2_valid !== e.v || bus.rs2_val !== e.val || bus.rs2_tag !== e.tg) begin
            fails++;
            $display("FAIL %s: rs2 got valid=%b val=%h tag=%0d, want valid=%b val=%h tag=%0d",
                     e.name, bus.rs2_valid, bus.rs2_val, bus.rs2_tag, e.v, e.val, e.tg);
          end
        end else begin
          if (bus.dispatch_ready !== e.rdy || bus.flush !== e.fl ||
              bus.mem_flush !== e.mf || bus.br_addr !== e.ba) begin
            fails++;
            $display("FAIL %s: got ready=%b flush=%b mem_flush=%b br_addr=%h, want ready=%b flush=%b mem_flush=%b br_addr=%h",
                     e.name, bus.dispatch_ready, bus.flush, bus.mem_flush, bus.br_addr,
                     e.rdy, e.fl, e.mf, e.ba);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    cyc = 0; tests = 0; fails = 0; stim_done = 1'b0;
    rst = 1'b0;
    bus.dispatch_valid = 1'b0; bus.dispatch_rd = '0; bus.dispatch_tag = '0;
    bus.rs1_idx = '0; bus.rs2_idx = '0;
    bus.commit_valid = 1'b0; bus.commit_rd = '0; bus.commit_tag = '0; bus.commit_val = '0;
    bus.commit_mispredict = 1'b0; bus.commit_br_target = '0;
    bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_val = '0;

    // reset state
    step(); bus.rs1_idx = 5'd5;
    chk_rd(0, "reset_rs1", 1'b1, 32'h0, 4'd0);
    chk_ctl("reset_ctl", 1'b1, 1'b0, 1'b0, 32'h0);
    step(); rst = 1'b1;

    // rename then commit with bypass
    step(); dispatch(5'd3, 4'd7);
    chk_ctl("run_ready", 1'b1, 1'b0, 1'b0, 32'h0);
    step(); bus.rs1_idx = 5'd3;
    chk_rd(0, "rename_busy", 1'b0, 32'h0, 4'd7);
    step(); commit(5'd3, 4'd7, 32'h0000DEAD); bus.rs1_idx = 5'd3;
    chk_rd(0, "commit_bypass", 1'b1, 32'h0000DEAD, 4'd0);
    step(); bus.rs1_idx = 5'd3;
    chk_rd(0, "commit_visible", 1'b1, 32'h0000DEAD, 4'd0);

    // older commit must not free a younger mapping
    step(); dispatch(5'd4, 4'd2);
    step(); dispatch(5'd4, 4'd5);
    step(); commit(5'd4, 4'd2, 32'h11); bus.rs1_idx = 5'd4;
    chk_rd(0, "old_commit_same", 1'b0, 32'h0, 4'd5);
    step(); bus.rs1_idx = 5'd4;
    chk_rd(0, "young_kept", 1'b0, 32'h0, 4'd5);
    step(); commit(5'd4, 4'd5, 32'h22); dispatch(5'd4, 4'd9); bus.rs1_idx = 5'd4;
    chk_rd(0, "commit_rename_byp", 1'b1, 32'h22, 4'd0);
    step(); bus.rs1_idx = 5'd4;
    chk_rd(0, "rename_wins", 1'b0, 32'h0, 4'd9);
    step(); commit(5'd4, 4'd9, 32'h33);
    step(); bus.rs1_idx = 5'd4;
    chk_rd(0, "final_value", 1'b1, 32'h33, 4'd0);

    // CDB broadcast
    step(); dispatch(5'd8, 4'd3);
    step(); bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd3; bus.cdb_val = 32'h55; bus.rs2_idx = 5'd8;
`ifdef RENAME_RF_CDB_BYPASS_EN
    chk_rd(1, "cdb_bypass", 1'b1, 32'h55, 4'd0);
`else
    chk_rd(1, "cdb_ignored", 1'b0, 32'h0, 4'd3);
`endif
    step(); bus.rs2_idx = 5'd8;
    chk_rd(1, "cdb_gone", 1'b0, 32'h0, 4'd3);

    // mispredict with concurrent wrong-path dispatch
    step(); commit(5'd10, 4'd0, 32'hABC); bus.commit_mispredict = 1'b1;
    bus.commit_br_target = 32'h80000040; dispatch(5'd6, 4'd1); bus.rs1_idx = 5'd8;
    chk_rd(0, "mp_cycle_rs1", 1'b0, 32'h0, 4'd3);
    chk_ctl("mp_cycle_ctl", 1'b1, 1'b0, 1'b1, 32'h0);
    // flush cycle: dispatch refused, second mispredict ignored
    step(); bus.rs1_idx = 5'd6; bus.rs2_idx = 5'd8;
    dispatch(5'd7, 4'd2);
    commit(5'd0, 4'd0, 32'h0); bus.commit_mispredict = 1'b1; bus.commit_br_target = 32'h1234;
    chk_rd(0, "flush_x6_free", 1'b1, 32'h0, 4'd0);
    chk_rd(1, "flush_x8_free", 1'b1, 32'h0, 4'd0);
    chk_ctl("flush_ctl", 1'b0, 1'b1, 1'b1, 32'h80000040);
    step(); bus.rs1_idx = 5'd10; bus.rs2_idx = 5'd7;
    chk_rd(0, "mp_value_written", 1'b1, 32'hABC, 4'd0);
    chk_rd(1, "flush_dispatch_drop", 1'b1, 32'h0, 4'd0);
    chk_ctl("after_flush_ctl", 1'b1, 1'b0, 1'b0, 32'h80000040);

    // x0 ignores rename and commit
    step(); dispatch(5'd0, 4'd4); commit(5'd0, 4'd4, 32'hFF);
    bus.rs1_idx = 5'd0; bus.rs2_idx = 5'd0;
    chk_rd(0, "x0_same_rs1", 1'b1, 32'h0, 4'd0);
    chk_rd(1, "x0_same_rs2", 1'b1, 32'h0, 4'd0);
    step(); bus.rs1_idx = 5'd0;
    chk_rd(0, "x0_after", 1'b1, 32'h0, 4'd0);

    // asynchronous reset mid-run
    step(); dispatch(5'd5, 4'd6);
    step(); bus.rs1_idx = 5'd5;
    chk_rd(0, "pre_reset_busy", 1'b0, 32'h0, 4'd6);
    step(); rst = 1'b0; bus.rs1_idx = 5'd5;
    chk_rd(0, "async_reset_rs1", 1'b1, 32'h0, 4'd0);
    chk_ctl("async_reset_ctl", 1'b1, 1'b0, 1'b0, 32'h0);
    step(); rst = 1'b1; bus.rs1_idx = 5'd3;
    chk_rd(0, "reset_cleared_val", 1'b1, 32'h0, 4'd0);

    stim_done = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
